// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory with byte-lane writes and fixed-latency reads.
// Reads and rejected accesses are reported through one-cycle rvalid/err pulses.
module data_mem_responder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_en,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_rvalid,
   output logic        mem_busy,
   output logic        mem_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   state_t                  state_reg, state_next;
   logic [2:0]              wait_cnt_reg, wait_cnt_next;
   logic [ADDR_WIDTH-1:0]   rd_idx_reg;
   logic                    rd_ok_reg;
   logic [31:0]             rdata_reg;
   logic                    err_reg;
   logic [31:0]             mem [DEPTH];

   logic                    req_ok;
   logic [ADDR_WIDTH-1:0]   req_idx;
   logic                    accept, is_write, wr_fire, rd_accept;
   logic [ADDR_WIDTH-1:0]   load_idx;
   logic                    load_ok, load_resp, wr_err;

   assign req_ok    = (mem_addr[1:0] == 2'b00) && ((mem_addr >> (ADDR_WIDTH + 2)) == 32'd0);
   assign req_idx   = mem_addr[ADDR_WIDTH+1:2];
   assign accept    = resetn && mem_en && (state_reg == IDLE || state_reg == RESP);
   assign is_write  = (mem_wen != 4'b0000);
   assign wr_fire   = accept && is_write && req_ok;
   assign wr_err    = accept && is_write && !req_ok;
   assign rd_accept = accept && !is_write;

   // Latency-1 reads load straight from the request; longer ones use the latched address.
   assign load_idx  = (state_reg == RD_WAIT) ? rd_idx_reg : req_idx;
   assign load_ok   = (state_reg == RD_WAIT) ? rd_ok_reg  : req_ok;
   assign load_resp = (state_next == RESP);

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         IDLE, RESP: begin
            if (rd_accept) begin
               if (READ_LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next    = RD_WAIT;
                  wait_cnt_next = 3'(READ_LATENCY - 2);
               end
            end else begin
               state_next = IDLE;
            end
         end
         RD_WAIT: begin
            if (wait_cnt_reg == 3'd0) begin
               state_next = RESP;
            end else begin
               wait_cnt_next = wait_cnt_reg - 3'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 3'd0;
         rd_idx_reg   <= '0;
         rd_ok_reg    <= 1'b0;
         rdata_reg    <= 32'd0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (rd_accept) begin
            rd_idx_reg <= req_idx;
            rd_ok_reg  <= req_ok;
         end
         if (load_resp) begin
            rdata_reg <= load_ok ? mem[load_idx] : 32'd0;
         end
         err_reg <= wr_err || (load_resp && !load_ok);
      end
   end

   // Array is intentionally not reset so contents survive resetn.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wen[i]) begin
               mem[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_rdata  = rdata_reg;
   assign mem_rvalid = (state_reg == RESP);
   assign mem_busy   = (state_reg == RD_WAIT);
   assign mem_err    = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two instances (read latency 1 and 3) driven by directed and
// random requests, checked cycle by cycle against an array-based reference model.
module tb_data_mem_responder;

   localparam int AW = 10;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } rd_t;

   logic        clk = 1'b0;
   logic        rstn_s   [2];
   logic        en_s     [2];
   logic [3:0]  wen_s    [2];
   logic [31:0] addr_s   [2];
   logic [31:0] wdata_s  [2];
   logic [31:0] rdata_s  [2];
   logic        rvalid_s [2];
   logic        busy_s   [2];
   logic        err_s    [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g
         localparam int LAT = (gi == 0) ? 1 : 3;

         data_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
            .clk        (clk),
            .resetn     (rstn_s[gi]),
            .mem_en     (en_s[gi]),
            .mem_wen    (wen_s[gi]),
            .mem_addr   (addr_s[gi]),
            .mem_wdata  (wdata_s[gi]),
            .mem_rdata  (rdata_s[gi]),
            .mem_rvalid (rvalid_s[gi]),
            .mem_busy   (busy_s[gi]),
            .mem_err    (err_s[gi])
         );

         logic [31:0]   ref_mem [1 << AW];
         rd_t           rdq [$];
         int            werrq [$];
         int            cyc = 0;
         int            busy_lo = 0, busy_hi = -1, ready_at = 0;
         logic [31:0]   last_rd = 32'd0;
         int            c;
         logic          legal;
         logic [AW-1:0] w;
         logic          exp_rv, exp_err, exp_busy;

         always @(negedge rstn_s[gi]) begin
            rdq.delete();
            werrq.delete();
            busy_hi  = -1;
            ready_at = 0;
            last_rd  = 32'd0;
         end

         // Reference: requests accepted when not inside a read's busy window.
         always @(posedge clk) begin
            cyc++;
            c = cyc;
            if (rstn_s[gi] && en_s[gi] && c >= ready_at) begin
               legal = (addr_s[gi][1:0] == 2'b00) && (addr_s[gi] < (32'd1 << (AW + 2)));
               w     = addr_s[gi][AW+1:2];
               if (wen_s[gi] != 4'b0000) begin
                  if (legal) begin
                     for (int i = 0; i < 4; i++)
                        if (wen_s[gi][i]) ref_mem[w][8*i +: 8] = wdata_s[gi][8*i +: 8];
                  end else begin
                     werrq.push_back(c);
                  end
               end else begin
                  rdq.push_back('{due: c + LAT - 1, data: (legal ? ref_mem[w] : 32'd0), err: !legal});
                  busy_lo  = c;
                  busy_hi  = c + LAT - 2;
                  ready_at = c + LAT;
               end
            end
         end

         always @(negedge clk) begin
            if (!rstn_s[gi]) begin
               chk($sformatf("L%0d reset_outputs", LAT),
                   {rdata_s[gi] | {29'd0, rvalid_s[gi], busy_s[gi], err_s[gi]}}, 32'd0);
            end else begin
               exp_rv   = (rdq.size() > 0) && (rdq[0].due == cyc);
               exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
               exp_err  = ((werrq.size() > 0) && (werrq[0] == cyc)) || (exp_rv && rdq[0].err);
               chk($sformatf("L%0d busy c%0d", LAT, cyc), {31'd0, busy_s[gi]}, {31'd0, exp_busy});
               chk($sformatf("L%0d rvalid c%0d", LAT, cyc), {31'd0, rvalid_s[gi]}, {31'd0, exp_rv});
               chk($sformatf("L%0d err c%0d", LAT, cyc), {31'd0, err_s[gi]}, {31'd0, exp_err});
               if (exp_rv) begin
                  last_rd = rdq[0].data;
                  void'(rdq.pop_front());
               end
               chk($sformatf("L%0d rdata c%0d", LAT, cyc), rdata_s[gi], last_rd);
               if ((werrq.size() > 0) && (werrq[0] == cyc)) void'(werrq.pop_front());
            end
         end
      end
   endgenerate

   task automatic drive(int k, logic e, logic [3:0] wn, logic [31:0] a, logic [31:0] d);
      en_s[k]    = e;
      wen_s[k]   = wn;
      addr_s[k]  = a;
      wdata_s[k] = d;
      @(posedge clk);
      #1;
      en_s[k] = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic random_phase(int k, int n);
      logic [31:0] a;
      logic [3:0]  wn;
      int          sel;
      for (int i = 0; i < 16; i++) drive(k, 1'b1, 4'hF, i << 2, $urandom);
      for (int i = 0; i < n; i++) begin
         sel = $urandom_range(0, 9);
         a   = $urandom_range(0, 15) << 2;
         if (sel == 8) a = a | $urandom_range(1, 3);
         if (sel == 9) a = a | (32'h1000 << $urandom_range(0, 19));
         wn  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         drive(k, ($urandom_range(0, 3) != 0), wn, a, $urandom);
      end
      idle(6);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rstn_s[k]  = 1'b0;
         en_s[k]    = 1'b0;
         wen_s[k]   = 4'h0;
         addr_s[k]  = 32'd0;
         wdata_s[k] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      rstn_s[0] = 1'b1;
      rstn_s[1] = 1'b1;

      // Latency 1: write/read, byte-lane merge, illegal accesses, back-to-back reads.
      drive(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
      idle(2);
      drive(0, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
      drive(0, 1'b1, 4'b0010, 32'h20, 32'h00005500);
      drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
      idle(2);
      drive(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D);
      drive(0, 1'b1, 4'h0, 32'h12, 32'h0);
      drive(0, 1'b1, 4'h0, 32'h1000, 32'h0);
      drive(0, 1'b1, 4'hF, 32'h1000, 32'h12345678);
      drive(0, 1'b1, 4'h0, 32'h0, 32'h0);
      idle(2);
      drive(0, 1'b1, 4'hF, 32'h14, 32'h14141414);
      drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
      drive(0, 1'b1, 4'h0, 32'h14, 32'h0);
      idle(3);

      // Latency 3: address change and ignored write during the wait.
      drive(1, 1'b1, 4'hF, 32'h10, 32'hAAAA1010);
      drive(1, 1'b1, 4'hF, 32'h20, 32'hBBBB2020);
      drive(1, 1'b1, 4'h0, 32'h10, 32'h0);
      drive(1, 1'b1, 4'hF, 32'h20, 32'hBAD0BAD0);
      drive(1, 1'b1, 4'hF, 32'h20, 32'hBAD1BAD1);
      idle(3);
      drive(1, 1'b1, 4'h0, 32'h20, 32'h0);
      idle(4);

      // Latency 3: reset while waiting discards the read, contents survive.
      drive(1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
      drive(1, 1'b1, 4'h0, 32'h30, 32'h0);
      #2;
      rstn_s[1] = 1'b0;
      #1;
      chk("L3 async_reset_busy", {31'd0, busy_s[1]}, 32'd0);
      chk("L3 async_reset_rdata", rdata_s[1], 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstn_s[1] = 1'b1;
      idle(6);
      drive(1, 1'b1, 4'h0, 32'h30, 32'h0);
      idle(5);

      random_phase(0, 300);
      random_phase(1, 300);

      idle(8);
      chk("L1 queue_drained", 32'(g[0].rdq.size()), 32'd0);
      chk("L3 queue_drained", 32'(g[1].rdq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the word-address width (2^ADDR_WIDTH 32-bit words).
REQ-002 The block SHALL have parameter READ_LATENCY, default 1, legal range 1..7, the number of cycles from read accept to rvalid.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port mem_en, input, 1 bit, the request strobe from the control FSM.
REQ-006 The block SHALL have port mem_wen, input, 4 bits, the byte write enables; 4'b0000 means read.
REQ-007 The block SHALL have port mem_addr, input, 32 bits, the byte address.
REQ-008 The block SHALL have port mem_wdata, input, 32 bits, the write data; lane i is bits [8i+7:8i].
REQ-009 The block SHALL have port mem_rdata, output, 32 bits, the registered read data.
REQ-010 The block SHALL have port mem_rvalid, output, 1 bit, a one-cycle pulse marking read completion.
REQ-011 The block SHALL have port mem_busy, output, 1 bit, high while a read is in flight and new requests are refused.
REQ-012 The block SHALL have port mem_err, output, 1 bit, a one-cycle pulse marking a rejected access.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RD_WAIT and RESP.
REQ-014 A request SHALL be accepted on a rising edge where mem_en=1 and the state is IDLE or RESP; mem_en while mem_busy=1 SHALL be ignored with no side effects.
REQ-015 Access legality: mem_addr[1:0]!=0 or mem_addr[31:ADDR_WIDTH+2]!=0 SHALL make the access illegal.
REQ-016 Word index SHALL be mem_addr[ADDR_WIDTH+1:2].
REQ-017 A legal write (mem_wen!=0) SHALL update only enabled byte lanes at the accept edge; it SHALL complete in one cycle, with no rvalid and no busy.
REQ-018 A write SHALL leave the state unchanged if accepted in IDLE, and SHALL move it to IDLE if accepted in RESP.
REQ-019 A read accept SHALL latch the address and legality, and inputs after accept SHALL have no effect on that read.
REQ-020 With READ_LATENCY=1, a read accept SHALL go to RESP, so that mem_rdata and mem_rvalid=1 appear in the cycle after accept; mem_busy SHALL never assert.
REQ-021 With READ_LATENCY=N>1, a read accept SHALL go to RD_WAIT for N-1 cycles (mem_busy=1 throughout), then to RESP (mem_rvalid=1, mem_busy=0).
REQ-022 From RESP, the FSM SHALL return to IDLE unless a new read is accepted in the same cycle, which restarts the sequence (back-to-back reads allowed).
REQ-023 mem_rdata SHALL update only in RESP and SHALL hold its value until the next read completes.
REQ-024 An illegal write SHALL not modify the array and SHALL pulse mem_err in the cycle after accept.
REQ-025 An illegal read SHALL complete with normal timing, with mem_rdata=32'h0, mem_rvalid=1 and mem_err=1 in the RESP cycle.
REQ-026 The block SHALL not check ordering between reads and writes beyond request order; a read following a write to the same word SHALL return the written data.
REQ-027 Array contents SHALL not be reset and SHALL be undefined until written.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, mem_rdata=0, mem_rvalid=0, mem_busy=0 and mem_err=0, independent of clk.
REQ-029 Reset mid-read SHALL discard the pending read with no rvalid after release; array contents SHALL be preserved.
REQ-030 The first accept SHALL occur on the first rising edge with resetn=1 and mem_en=1.

Verification
REQ-031 Write addr 0x10, wen 1111, data 0xDEADBEEF, then read 0x10 (latency 1) -> next cycle rdata=0xDEADBEEF, rvalid=1, err=0, busy never 1.
REQ-032 Write 0xDEADBEEF at 0x20, then write wen 0010 with data 0x00005500, then read 0x20 -> rdata=0xDEAD55EF.
REQ-033 READ_LATENCY=3, read 0x10 with mem_addr changed to 0x20 during wait -> busy=1 for 2 cycles, a request during busy is ignored, then rvalid=1 with data from 0x10.
REQ-034 Read 0x12 (misaligned), and read 0x00001000 with ADDR_WIDTH=10 (out of range) -> each gives rvalid=1, err=1, rdata=0; an illegal write to 0x1000 leaves word 0 unchanged and err pulses.
REQ-035 READ_LATENCY=3, assert resetn=0 mid RD_WAIT -> outputs 0 asynchronously, no rvalid after release, and a later read of a previously written word returns its data.
REQ-036 Back-to-back reads 0x10 and 0x14 at latency 1 -> rvalid high for two consecutive cycles with the correct data each cycle.
